// File: rtl/crt_pkg.sv
// Shared timing constants, store geometry and stage-1 pipeline record for the
// CRT raster scanner.
package crt_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 40;
    localparam int H_SYNC_DEF    = 128;
    localparam int H_BACK_DEF    = 88;
    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 1;
    localparam int V_SYNC_DEF    = 4;
    localparam int V_BACK_DEF    = 23;
    localparam int H_OFFSET_DEF  = 144;
    localparam int V_OFFSET_DEF  = 44;
    localparam int SYNC_POS_DEF  = 1;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int CELL_SIZE   = 16;
    localparam int STORE_WORDS = 32;
    localparam int WORD_BITS   = 32;
    localparam int WIN_SIZE    = CELL_SIZE * STORE_WORDS;

    localparam int CELL_W = $clog2(CELL_SIZE);
    localparam int IDX_W  = $clog2(WORD_BITS);
    localparam int ADDR_W = $clog2(STORE_WORDS);

    // Counter widths cover 1056 columns and 628 lines.
    localparam int H_W = 11;
    localparam int V_W = 10;

    typedef struct packed {
        logic [IDX_W-1:0]  bit_idx;
        logic [CELL_W-1:0] cell_x;
        logic [CELL_W-1:0] cell_y;
        logic              in_win;
        logic              active;
        logic              hs;
        logic              vs;
    } stage1_t;

endpackage

// File: rtl/crt_timing_gen.sv
// Stage-0 raster counters with active-area and raw (active-high) sync decode.
module crt_timing_gen
    import crt_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           hs_raw,
    output logic           vs_raw
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_VISIBLE);
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_VISIBLE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] VS_START = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
        h_cnt_d = h_cnt_q + H_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking updates so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs_raw = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_raw = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

endmodule

// File: rtl/crt_raster_scan.sv
// Raster scanner: reads store words, picks the bit for the current 16x16 cell
// and muxes the on/off dot-mask pixel into registered video with aligned syncs.
module crt_raster_scan
    import crt_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int H_OFFSET  = H_OFFSET_DEF,
    parameter int V_OFFSET  = V_OFFSET_DEF,
    parameter int SYNC_POS  = SYNC_POS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [4:0]  store_addr,
    input  logic [31:0] store_data,
    output logic [3:0]  cell_x,
    output logic [3:0]  cell_y,
    input  logic        pixel_on,
    input  logic        pixel_off,
    output logic        video,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam logic           SYNC_ACT = (SYNC_POS != 0);
    localparam logic [H_W-1:0] WIN_H_LO = H_W'(H_OFFSET);
    localparam logic [H_W-1:0] WIN_H_HI = H_W'(H_OFFSET + WIN_SIZE);
    localparam logic [V_W-1:0] WIN_V_LO = V_W'(V_OFFSET);
    localparam logic [V_W-1:0] WIN_V_HI = V_W'(V_OFFSET + WIN_SIZE);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active, hs_raw, vs_raw;

    crt_timing_gen #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw)
    );

    logic       win_h, win_v;
    logic [8:0] rel_h, rel_v;

    // Only the low 9 bits of the window-relative position are ever consumed.
    assign win_h      = (h_cnt >= WIN_H_LO) && (h_cnt < WIN_H_HI);
    assign win_v      = (v_cnt >= WIN_V_LO) && (v_cnt < WIN_V_HI);
    assign rel_h      = 9'(h_cnt - WIN_H_LO);
    assign rel_v      = 9'(v_cnt - WIN_V_LO);
    assign store_addr = win_v ? rel_v[8:4] : '0;

    stage1_t s1_d, s1_q;
    logic    first_s1_d, first_s1_q;

    always_comb begin
        s1_d         = '0;
        s1_d.bit_idx = rel_h[8:4];
        s1_d.cell_x  = rel_h[3:0];
        s1_d.cell_y  = rel_v[3:0];
        s1_d.in_win  = win_h & win_v;
        s1_d.active  = active;
        s1_d.hs      = hs_raw;
        s1_d.vs      = vs_raw;
    end

    assign first_s1_d = (h_cnt == '0) && (v_cnt == '0);

    logic video_d, video_q;
    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic frame_d, frame_q;

    // The store word and both mask pixels are valid in stage 1, so the mux lands in stage 2.
    always_comb begin
        video_d = enable & s1_q.active & s1_q.in_win &
                  (store_data[s1_q.bit_idx] ? pixel_on : pixel_off);
        hsync_d = SYNC_ACT ? s1_q.hs : ~s1_q.hs;
        vsync_d = SYNC_ACT ? s1_q.vs : ~s1_q.vs;
        frame_d = first_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            first_s1_q <= 1'b0;
            video_q    <= 1'b0;
            hsync_q    <= ~SYNC_ACT;
            vsync_q    <= ~SYNC_ACT;
            frame_q    <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            first_s1_q <= first_s1_d;
            video_q    <= video_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            frame_q    <= frame_d;
        end
    end

    assign cell_x      = s1_q.cell_x;
    assign cell_y      = s1_q.cell_y;
    assign video       = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_crt_raster_scan.sv
// Bench for crt_raster_scan: external store and mask tables, with an arithmetic
// pixel-position model predicting every output each cycle.
module tb_crt_raster_scan;

    localparam int HT = 1056;
    localparam int VT = 628;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [4:0]  store_addr;
    logic [31:0] store_data = '0;
    logic [3:0]  cell_x, cell_y;
    logic        pixel_on, pixel_off;
    logic        video, hsync, vsync, frame_start;

    logic [31:0] mem [32];
    logic        on_tab  [256];
    logic        off_tab [256];
    logic        force_ones = 1'b0;
    logic        en_smp = 1'b0;
    int          n = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct packed {
        logic       video;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [4:0] addr;
        logic [3:0] cx;
        logic [3:0] cy;
    } obs_t;

    crt_raster_scan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .pixel_on    (pixel_on),
        .pixel_off   (pixel_off),
        .video       (video),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) store_data <= mem[store_addr];
    always @(posedge clk) en_smp <= enable;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    assign pixel_on  = force_ones | on_tab[{cell_y, cell_x}];
    assign pixel_off = force_ones | off_tab[{cell_y, cell_x}];

    // Expected outputs k clocks after reset release: store address follows pixel k,
    // cell coordinates pixel k-1, video/syncs/frame_start pixel k-2.
    function automatic obs_t expect_at(int k);
        obs_t e;
        int   h, v, rh, rv, idx;
        logic b;
        e = '0;
        v = (k / HT) % VT;
        if (v >= 44 && v < 556) e.addr = 5'((v - 44) / 16);
        if (k >= 1) begin
            h = (k - 1) % HT;
            v = ((k - 1) / HT) % VT;
            e.cx = 4'((h + 2048 - 144) % 16);
            e.cy = 4'((v + 1024 - 44) % 16);
        end
        if (k >= 2) begin
            h = (k - 2) % HT;
            v = ((k - 2) / HT) % VT;
            e.hs = (h >= 840 && h < 968);
            e.vs = (v >= 601 && v < 605);
            e.fs = (h == 0 && v == 0);
            if (en_smp && h < 800 && v < 600 && h >= 144 && h < 656 && v >= 44 && v < 556) begin
                rh  = h - 144;
                rv  = v - 44;
                idx = (rv % 16) * 16 + rh % 16;
                b   = mem[rv / 16][rh / 16];
                e.video = force_ones | (b ? on_tab[idx] : off_tab[idx]);
            end
        end
        return e;
    endfunction

    function automatic obs_t observed();
        return {video, hsync, vsync, frame_start, store_addr, cell_x, cell_y};
    endfunction

    function automatic int pix_h();
        return (n - 2) % HT;
    endfunction

    function automatic int pix_v();
        return ((n - 2) / HT) % VT;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (observed() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", observed(), obs_t'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== expect_at(n)) begin
            errors++;
            $display("FAIL reset_first_clk n=%0d got=%h exp=%h", n, observed(), expect_at(n));
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || video !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_start n=%0d got fs=%b v=%b hs=%b vs=%b exp fs=1 v=0 hs=0 vs=0",
                     n, frame_start, video, hsync, vsync);
        end
    endtask

    task automatic test_hsync();
        int   rise[$];
        int   fall[$];
        logic prev;
        prev = hsync;
        for (int k = 0; k < 2 * HT + 200; k++) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL hsync_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
            if (hsync && !prev) rise.push_back(n);
            if (!hsync && prev) fall.push_back(n);
            prev = hsync;
        end
        checks++;
        if (rise.size() < 2 || rise[0] != 842 || rise[1] != 842 + HT) begin
            errors++;
            $display("FAIL hsync_rise got count=%0d first=%0d second=%0d exp first=842 second=%0d",
                     rise.size(), (rise.size() > 0) ? rise[0] : -1, (rise.size() > 1) ? rise[1] : -1, 842 + HT);
        end
        checks++;
        if (rise.size() < 1 || fall.size() < 1 || fall[0] - rise[0] != 128) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=128",
                     (rise.size() > 0 && fall.size() > 0) ? fall[0] - rise[0] : -1);
        end
    endtask

    task automatic test_dot_pattern();
        foreach (mem[i]) mem[i] = '0;
        mem[0] = 32'h0000_0001;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                on_tab[y * 16 + x]  = (x >= 1 && x <= 14 && y >= 1 && y <= 14);
                off_tab[y * 16 + x] = ((y == 7 || y == 8) && (x == 0 || x == 15));
            end
        end
        while (n < 53 * HT + 2) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL dot_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
            if (pix_v() == 51 && pix_h() >= 145 && pix_h() <= 158) begin
                checks++;
                if (video !== 1'b1) begin
                    errors++;
                    $display("FAIL dot_on h=%0d got=%b exp=1", pix_h(), video);
                end
            end
            if (pix_v() == 51 && pix_h() >= 161 && pix_h() <= 174) begin
                checks++;
                if (video !== 1'b0) begin
                    errors++;
                    $display("FAIL dot_off h=%0d got=%b exp=0", pix_h(), video);
                end
            end
        end
    endtask

    task automatic test_random();
        foreach (mem[i]) mem[i] = $urandom;
        for (int i = 0; i < 256; i++) begin
            on_tab[i]  = 1'($urandom);
            off_tab[i] = 1'($urandom);
        end
        while (n < 63 * HT + 2) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL random_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
            enable = ($urandom_range(0, 7) != 0);
        end
        enable = 1'b1;
    endtask

    task automatic test_border();
        force_ones = 1'b1;
        while (n < 64 * HT + 2) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL border_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
            if (pix_v() == 63 && (pix_h() == 143 || pix_h() == 656 || pix_h() == 900)) begin
                checks++;
                if (video !== 1'b0) begin
                    errors++;
                    $display("FAIL border_black h=%0d got=%b exp=0", pix_h(), video);
                end
            end
            if (pix_v() == 63 && pix_h() == 144) begin
                checks++;
                if (video !== 1'b1) begin
                    errors++;
                    $display("FAIL border_edge h=144 got=%b exp=1", video);
                end
            end
        end
    endtask

    task automatic test_enable();
        while (n < 65 * HT + 2) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL enable_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
            if (pix_v() == 64 && pix_h() == 300) begin
                checks++;
                if (video !== 1'b0) begin
                    errors++;
                    $display("FAIL enable_off h=300 got=%b exp=0", video);
                end
            end
            if (pix_v() == 64 && pix_h() == 299) enable = 1'b0;
            if (pix_v() == 64 && pix_h() == 700) enable = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        int fs_count;
        while (!(pix_v() == 65 && pix_h() == 400)) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL pre_reset_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
        end
        checks++;
        if (video !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_video got=%b exp=1", video);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== obs_t'(0)) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", observed(), obs_t'(0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fs_count = 0;
        for (int k = 0; k < HT + 50; k++) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_at(n)) begin
                errors++;
                $display("FAIL post_reset_run n=%0d got=%h exp=%h", n, observed(), expect_at(n));
            end
            if (frame_start === 1'b1) fs_count++;
            if (n == 2) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL post_reset_fs n=2 got=%b exp=1", frame_start);
                end
            end
        end
        checks++;
        if (fs_count != 1) begin
            errors++;
            $display("FAIL post_reset_fs_count got=%0d exp=1", fs_count);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        for (int i = 0; i < 256; i++) begin
            on_tab[i]  = 1'b0;
            off_tab[i] = 1'b0;
        end
        test_reset();
        test_hsync();
        test_dot_pattern();
        test_random();
        test_border();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
